// File: rtl/instruction_fetch_stage_pkg.sv
// Shared definitions for the fetch stage and decoder: word width, NOP word, opcodes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instruction_fetch_stage_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // Encodes sll $0,$0,0, which the decoder treats as a no-op.
    localparam word_t NOP_WORD_DEFAULT = 32'h0000_0000;

    // Primary opcodes, already decoded downstream.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Forces a byte address onto a word boundary. A misaligned target is
    // silently truncated rather than raising a fault.
    function automatic word_t align_word(input word_t addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_stage_instruction_memory.sv
// Word-addressed instruction memory: combinational read port, synchronous write port.
// Latency: read is combinational; a write becomes visible the cycle after the write edge.
// Backpressure: none; a write is accepted on every edge with we_i=1. Contents are never reset.
module instruction_memory
    import instruction_fetch_stage_pkg::*;
#(
    parameter int IMEM_DEPTH = 256
) (
    input  logic                          clk_i,
    input  logic                          we_i,
    input  logic [$clog2(IMEM_DEPTH)-1:0] waddr_i,
    input  word_t                         wdata_i,
    input  logic [$clog2(IMEM_DEPTH)-1:0] raddr_i,
    output word_t                         rdata_o
);

    word_t mem_q [IMEM_DEPTH];

    // No reset: program images loaded before or during reset must survive it.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // The fetch register samples this on the same edge as a write, so a
    // same-word fetch captures the old contents.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: PC register, instruction memory read, IF/ID register and fetch counter.
// Latency: the word at PC X appears on id_instruction one edge after pc==X in a non-stalled cycle.
// Backpressure: stall holds PC, IF/ID and counter; redirect beats stall and squashes IF/ID to NOP.
// Ports: clk/reset (async, active-high), stall, redirect_valid/redirect_pc,
//        imem_we/imem_waddr/imem_wdata (load port), pc, id_instruction,
//        id_pc_plus4, id_valid, fetch_count.
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter int    IMEM_DEPTH = 256,   // power of two
    parameter word_t RESET_PC   = 32'h0000_0000,
    parameter word_t NOP_WORD   = NOP_WORD_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall,
    input  logic                          redirect_valid,
    input  logic [31:0]                   redirect_pc,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [31:0]                   imem_wdata,
    output logic [31:0]                   pc,
    output logic [31:0]                   id_instruction,
    output logic [31:0]                   id_pc_plus4,
    output logic                          id_valid,
    output logic [31:0]                   fetch_count
);

    localparam int AW = $clog2(IMEM_DEPTH);

    word_t pc_q,          pc_d;
    word_t id_instr_q,    id_instr_d;
    word_t id_pc4_q,      id_pc4_d;
    logic  id_valid_q,    id_valid_d;
    word_t fetch_count_q, fetch_count_d;

    logic [AW-1:0] fetch_idx;
    word_t         fetch_word;
    word_t         pc_plus4;

    // Upper PC bits are dropped, so fetches wrap modulo IMEM_DEPTH words.
    assign fetch_idx = pc_q[AW+1:2];
    // 32-bit modulo add: 32'hFFFF_FFFC wraps to 0.
    assign pc_plus4  = pc_q + 32'd4;

    instruction_memory #(
        .IMEM_DEPTH (IMEM_DEPTH)
    ) u_imem (
        .clk_i   (clk),
        .we_i    (imem_we),
        .waddr_i (imem_waddr),
        .wdata_i (imem_wdata),
        .raddr_i (fetch_idx),
        .rdata_o (fetch_word)
    );

    always_comb begin
        pc_d          = pc_q;
        id_instr_d    = id_instr_q;
        id_pc4_d      = id_pc4_q;
        id_valid_d    = id_valid_q;
        fetch_count_d = fetch_count_q;

        if (redirect_valid) begin
            // Squash the word being fetched this cycle; it is on the wrong path.
            pc_d       = align_word(redirect_pc);
            id_instr_d = NOP_WORD;
            id_pc4_d   = '0;
            id_valid_d = 1'b0;
        end else if (!stall) begin
            pc_d          = pc_plus4;
            id_instr_d    = fetch_word;
            id_pc4_d      = pc_plus4;
            id_valid_d    = 1'b1;
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            id_instr_q    <= NOP_WORD;
            id_pc4_q      <= '0;
            id_valid_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            id_instr_q    <= id_instr_d;
            id_pc4_q      <= id_pc4_d;
            id_valid_q    <= id_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign pc             = pc_q;
    assign id_instruction = id_instr_q;
    assign id_pc_plus4    = id_pc4_q;
    assign id_valid       = id_valid_q;
    assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
module tb_instruction_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic [31:0] pc;
    logic [31:0] id_instruction;
    logic [31:0] id_pc_plus4;
    logic        id_valid;
    logic [31:0] fetch_count;

    int errors = 0;
    int checks = 0;

    instruction_fetch_stage #(
        .IMEM_DEPTH (256),
        .RESET_PC   (32'h0000_0000),
        .NOP_WORD   (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_we        (imem_we),
        .imem_waddr     (imem_waddr),
        .imem_wdata     (imem_wdata),
        .pc             (pc),
        .id_instruction (id_instruction),
        .id_pc_plus4    (id_pc_plus4),
        .id_valid       (id_valid),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        we;
        logic [7:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
        logic [31:0] e_pc4;
        logic        e_vld;
        logic [31:0] e_cnt;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ins,
                           input logic [31:0] e_pc4, input logic e_vld, input logic [31:0] e_cnt);
        chk({tag, ".pc"},          pc,                    e_pc);
        chk({tag, ".instruction"}, id_instruction,        e_ins);
        chk({tag, ".pc_plus4"},    id_pc_plus4,           e_pc4);
        chk({tag, ".valid"},       {31'd0, id_valid},     {31'd0, e_vld});
        chk({tag, ".fetch_count"}, fetch_count,           e_cnt);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // stall redir rpc  we waddr wdata | pc  instr  pc+4 vld cnt
        vecs[0]  = '{0,0,32'h0,0,8'd0,32'h0, 32'h004, 32'h012A4020, 32'h004, 1, 32'd1};
        vecs[1]  = '{0,0,32'h0,0,8'd0,32'h0, 32'h008, 32'h8D090004, 32'h008, 1, 32'd2};
        vecs[2]  = '{1,0,32'h0,0,8'd0,32'h0, 32'h008, 32'h8D090004, 32'h008, 1, 32'd2};
        vecs[3]  = '{1,0,32'h0,0,8'd0,32'h0, 32'h008, 32'h8D090004, 32'h008, 1, 32'd2};
        vecs[4]  = '{1,0,32'h0,0,8'd0,32'h0, 32'h008, 32'h8D090004, 32'h008, 1, 32'd2};
        vecs[5]  = '{0,0,32'h0,0,8'd0,32'h0, 32'h00C, 32'hC0000002, 32'h00C, 1, 32'd3};
        // redirect with simultaneous stall, misaligned target
        vecs[6]  = '{1,1,32'h43,0,8'd0,32'h0, 32'h040, 32'h0, 32'h0, 0, 32'd3};
        vecs[7]  = '{0,0,32'h0,0,8'd0,32'h0, 32'h044, 32'hC0000010, 32'h044, 1, 32'd4};
        // last word, then wrap of the word index
        vecs[8]  = '{0,1,32'h3FC,0,8'd0,32'h0, 32'h3FC, 32'h0, 32'h0, 0, 32'd4};
        vecs[9]  = '{0,0,32'h0,0,8'd0,32'h0, 32'h400, 32'hC00000FF, 32'h400, 1, 32'd5};
        vecs[10] = '{0,0,32'h0,0,8'd0,32'h0, 32'h404, 32'h012A4020, 32'h404, 1, 32'd6};
        // write-during-fetch returns old word; new word after refetch
        vecs[11] = '{0,1,32'h8,0,8'd0,32'h0, 32'h008, 32'h0, 32'h0, 0, 32'd6};
        vecs[12] = '{0,0,32'h0,1,8'd2,32'hDEADBEEF, 32'h00C, 32'hC0000002, 32'h00C, 1, 32'd7};
        vecs[13] = '{0,1,32'h8,0,8'd0,32'h0, 32'h008, 32'h0, 32'h0, 0, 32'd7};
        vecs[14] = '{0,0,32'h0,0,8'd0,32'h0, 32'h00C, 32'hDEADBEEF, 32'h00C, 1, 32'd8};
        // write lands while stalled
        vecs[15] = '{1,0,32'h0,1,8'd3,32'h12345678, 32'h00C, 32'hDEADBEEF, 32'h00C, 1, 32'd8};
        vecs[16] = '{0,0,32'h0,0,8'd0,32'h0, 32'h010, 32'h12345678, 32'h010, 1, 32'd9};
        // 32-bit PC wrap
        vecs[17] = '{0,1,32'hFFFFFFFE,0,8'd0,32'h0, 32'hFFFFFFFC, 32'h0, 32'h0, 0, 32'd9};
        vecs[18] = '{0,0,32'h0,0,8'd0,32'h0, 32'h000, 32'hC00000FF, 32'h000, 1, 32'd10};
        vecs[19] = '{0,0,32'h0,0,8'd0,32'h0, 32'h004, 32'h012A4020, 32'h004, 1, 32'd11};

        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_we        = 1'b0;
        imem_waddr     = 8'd0;
        imem_wdata     = 32'h0;

        // Preload memory while held in reset.
        imem_we = 1'b1;
        for (int i = 0; i < 256; i++) begin
            imem_waddr = 8'(i);
            case (i)
                0:       imem_wdata = 32'h012A4020;
                1:       imem_wdata = 32'h8D090004;
                default: imem_wdata = 32'hC000_0000 | 32'(i);
            endcase
            step();
        end
        imem_we = 1'b0;

        chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        reset = 1'b0;

        for (int v = 0; v < NV; v++) begin
            stall          = vecs[v].stall;
            redirect_valid = vecs[v].redir;
            redirect_pc    = vecs[v].rpc;
            imem_we        = vecs[v].we;
            imem_waddr     = vecs[v].waddr;
            imem_wdata     = vecs[v].wdata;
            step();
            chk_all($sformatf("vec%0d", v), vecs[v].e_pc, vecs[v].e_ins,
                    vecs[v].e_pc4, vecs[v].e_vld, vecs[v].e_cnt);
        end
        stall   = 1'b0;
        imem_we = 1'b0;

        // Asynchronous reset mid-cycle while a redirect is being requested.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        redirect_valid = 1'b0;
        step();
        chk_all("reset_held", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        reset = 1'b0;
        step();
        chk_all("restart", 32'h4, 32'h012A4020, 32'h4, 1'b1, 32'd1);
        step();
        chk_all("restart2", 32'h8, 32'h8D090004, 32'h8, 1'b1, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
